// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the 16-state TAP encoding, default opcodes and the
// fixed low bits loaded into the IR on Capture-IR.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_t;

  localparam logic [3:0] IDCODE_INSN_DEF = 4'h2;
  localparam logic [3:0] DEBUG_INSN_DEF  = 4'h8;
  localparam logic [3:0] BYPASS_INSN_DEF = 4'hF;

  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_sync.sv
// Brings tck/tms/tdi into the system clock domain through one shared flop
// chain and turns the synchronized tck into one-cycle rise/fall strobes.
module jtag_tap_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tms_s_o,
  output logic tdi_s_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  // Bit 3 is a post-reset valid marker travelling with the pin samples.
  logic [SYNC_STAGES-1:0][3:0] stage_q;
  logic [3:0] last_s;
  logic       vld_s;
  logic       tck_s;
  logic       tck_prev_q;
  logic       armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= {1'b1, tck_i, tms_i, tdi_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign last_s = stage_q[SYNC_STAGES-1];
  assign vld_s  = last_s[3];
  assign tck_s  = last_s[2];

  // Edges count only after a real synchronized low level has been seen, so
  // a tck already high when reset is released never looks like a rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      tck_prev_q <= tck_s;
      armed_q    <= armed_q | (vld_s & ~tck_s);
    end
  end

  assign tms_s_o    = last_s[1];
  assign tdi_s_o    = last_s[0];
  assign tck_rise_o = armed_q & tck_s & ~tck_prev_q;
  assign tck_fall_o = armed_q & ~tck_s & tck_prev_q;

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled IEEE 1149.1 TAP controller with IDCODE, BYPASS and DEBUG
// instructions; DEBUG routes the DR scan path through the external debug unit.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511c3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSN  = IR_WIDTH'(IDCODE_INSN_DEF),
  parameter logic [IR_WIDTH-1:0] DEBUG_INSN   = IR_WIDTH'(DEBUG_INSN_DEF),
  parameter logic [IR_WIDTH-1:0] BYPASS_INSN  = IR_WIDTH'(BYPASS_INSN_DEF),
  parameter int                  SYNC_STAGES  = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic tdo_oe_o,
  output logic debug_select_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic debug_tdi_o,
  input  logic debug_tdo_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

  logic tms_s, tdi_s, tck_rise, tck_fall;

  jtag_tap_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_n_i),
    .tck_i      (tck_pad_i),
    .tms_i      (tms_pad_i),
    .tdi_i      (tdi_pad_i),
    .tms_s_o    (tms_s),
    .tdi_s_o    (tdi_s),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

  tap_state_t state_q, state_d;

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_latch_q, ir_latch_d;
  logic [31:0]         idcode_sr_q, idcode_sr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                capture_q, capture_d;
  logic                shift_q, shift_d;
  logic                update_q, update_d;
  logic                debug_tdi_q, debug_tdi_d;

  logic sel_idcode, sel_debug, sel_bypass, dr_tdo;

  assign sel_idcode = (ir_latch_q == IDCODE_INSN);
  assign sel_debug  = (ir_latch_q == DEBUG_INSN);
  assign sel_bypass = (ir_latch_q == BYPASS_INSN) || !(sel_idcode || sel_debug);

  always_comb begin
    dr_tdo = bypass_q;
    if (sel_idcode)     dr_tdo = idcode_sr_q[0];
    else if (sel_debug) dr_tdo = debug_tdo_i;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        ST_TLR:      state_d = tms_s ? ST_TLR      : ST_RTI;
        ST_RTI:      state_d = tms_s ? ST_SEL_DR   : ST_RTI;
        ST_SEL_DR:   state_d = tms_s ? ST_SEL_IR   : ST_CAP_DR;
        ST_CAP_DR:   state_d = tms_s ? ST_EX1_DR   : ST_SH_DR;
        ST_SH_DR:    state_d = tms_s ? ST_EX1_DR   : ST_SH_DR;
        ST_EX1_DR:   state_d = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
        ST_PAUSE_DR: state_d = tms_s ? ST_EX2_DR   : ST_PAUSE_DR;
        ST_EX2_DR:   state_d = tms_s ? ST_UPD_DR   : ST_SH_DR;
        ST_UPD_DR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
        ST_SEL_IR:   state_d = tms_s ? ST_TLR      : ST_CAP_IR;
        ST_CAP_IR:   state_d = tms_s ? ST_EX1_IR   : ST_SH_IR;
        ST_SH_IR:    state_d = tms_s ? ST_EX1_IR   : ST_SH_IR;
        ST_EX1_IR:   state_d = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
        ST_PAUSE_IR: state_d = tms_s ? ST_EX2_IR   : ST_PAUSE_IR;
        ST_EX2_IR:   state_d = tms_s ? ST_UPD_IR   : ST_SH_IR;
        ST_UPD_IR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
        default:     state_d = ST_TLR;
      endcase
    end
  end

  always_comb begin
    ir_sr_d     = ir_sr_q;
    ir_latch_d  = ir_latch_q;
    idcode_sr_d = idcode_sr_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    debug_tdi_d = debug_tdi_q;
    capture_d   = 1'b0;
    shift_d     = 1'b0;
    update_d    = 1'b0;

    // Rising edge: act on the state being left.
    if (tck_rise) begin
      case (state_q)
        ST_CAP_IR: ir_sr_d = IR_CAPTURE;
        ST_SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        ST_CAP_DR: begin
          if (sel_idcode)      idcode_sr_d = IDCODE_VALUE;
          else if (sel_debug)  capture_d   = 1'b1;
          else if (sel_bypass) bypass_d    = 1'b0;
        end
        ST_SH_DR: begin
          if (sel_idcode) begin
            idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
          end else if (sel_debug) begin
            shift_d     = 1'b1;
            debug_tdi_d = tdi_s;
          end else if (sel_bypass) begin
            bypass_d    = tdi_s;
          end
        end
        default: ;
      endcase
    end

    // Falling edge: drive tdo and commit updates for the state just entered.
    if (tck_fall) begin
      tdo_oe_d = (state_q == ST_SH_IR) || (state_q == ST_SH_DR);
      tdo_d    = (state_q == ST_SH_IR) ? ir_sr_q[0] : dr_tdo;
      if (state_q == ST_UPD_IR) ir_latch_d = ir_sr_q;
      if (state_q == ST_UPD_DR) update_d   = sel_debug;
    end

    if (state_q == ST_TLR) ir_latch_d = IDCODE_INSN;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_TLR;
      ir_sr_q     <= '0;
      ir_latch_q  <= IDCODE_INSN;
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      capture_q   <= 1'b0;
      shift_q     <= 1'b0;
      update_q    <= 1'b0;
      debug_tdi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_latch_q  <= ir_latch_d;
      idcode_sr_q <= idcode_sr_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
      capture_q   <= capture_d;
      shift_q     <= shift_d;
      update_q    <= update_d;
      debug_tdi_q <= debug_tdi_d;
    end
  end

  assign tdo_pad_o          = tdo_q;
  assign tdo_oe_o           = tdo_oe_q;
  assign debug_select_o     = sel_debug;
  assign capture_dr_o       = capture_q;
  assign shift_dr_o         = shift_q;
  assign update_dr_o        = update_q;
  assign debug_tdi_o        = debug_tdi_q;
  assign test_logic_reset_o = (state_q == ST_TLR);
  assign run_test_idle_o    = (state_q == ST_RTI);

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: drives slow tck cycles, tracks the TAP
// with a table-driven protocol model and checks outputs after every cycle.
module tb_jtag_tap_sampled;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck = 1'b0, tms = 1'b0, tdi = 1'b0, dbg_tdo = 1'b0;
  logic tdo, tdo_oe, dsel, cap, shf, upd, dbg_tdi, tlr, rti;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .wb_clk_i           (clk),
    .wb_rst_n_i         (rst_n),
    .tck_pad_i          (tck),
    .tms_pad_i          (tms),
    .tdi_pad_i          (tdi),
    .tdo_pad_o          (tdo),
    .tdo_oe_o           (tdo_oe),
    .debug_select_o     (dsel),
    .capture_dr_o       (cap),
    .shift_dr_o         (shf),
    .update_dr_o        (upd),
    .debug_tdi_o        (dbg_tdi),
    .debug_tdo_i        (dbg_tdo),
    .test_logic_reset_o (tlr),
    .run_test_idle_o    (rti)
  );

  localparam int S_TLR = 0,  S_RTI = 1,  S_SELDR = 2,  S_CAPDR = 3;
  localparam int S_SHDR = 4, S_EX1DR = 5, S_PDR = 6,   S_EX2DR = 7;
  localparam int S_UPDDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11;
  localparam int S_EX1IR = 12, S_PIR = 13, S_EX2IR = 14, S_UPDIR = 15;

  int nxt0 [16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
                    S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
  int nxt1 [16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDDR, S_EX2DR, S_UPDDR,
                    S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPDIR, S_EX2IR, S_UPDIR, S_SELDR};

  int total = 0, bad = 0;

  int          m_state;
  logic [3:0]  m_ir, m_latch;
  logic [31:0] m_dr;
  logic        m_byp, exp_tdo, exp_oe;
  int          exp_cap = 0, exp_shift = 0, exp_upd = 0;
  int          got_cap = 0, got_shift = 0, got_upd = 0, oe_n = 0;
  logic        prev_cap = 1'b0, prev_shf = 1'b0, prev_upd = 1'b0;
  logic [31:0] rx = '0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_state = S_TLR; m_ir = '0; m_latch = 4'h2; m_dr = '0; m_byp = 1'b0;
    exp_tdo = 1'b0; exp_oe = 1'b0;
  endtask

  // Protocol model: rising edge acts on the state left, falling edge on the state entered.
  task automatic model_step(input logic t_ms, input logic t_di, input logic d_tdo);
    int cur;
    cur = m_state;
    case (cur)
      S_CAPIR: m_ir = 4'b0001;
      S_SHIR:  m_ir = {t_di, m_ir[3:1]};
      S_CAPDR: begin
        if (m_latch == 4'h2)      m_dr = 32'h149511c3;
        else if (m_latch == 4'h8) exp_cap++;
        else                      m_byp = 1'b0;
      end
      S_SHDR: begin
        if (m_latch == 4'h2)      m_dr = {t_di, m_dr[31:1]};
        else if (m_latch == 4'h8) exp_shift++;
        else                      m_byp = t_di;
      end
      default: ;
    endcase
    m_state = t_ms ? nxt1[cur] : nxt0[cur];
    exp_oe = (m_state == S_SHIR) || (m_state == S_SHDR);
    if (m_state == S_SHIR)    exp_tdo = m_ir[0];
    else if (m_latch == 4'h2) exp_tdo = m_dr[0];
    else if (m_latch == 4'h8) exp_tdo = d_tdo;
    else                      exp_tdo = m_byp;
    if (m_state == S_UPDIR) m_latch = m_ir;
    if (m_state == S_UPDDR && m_latch == 4'h8) exp_upd++;
    if (m_state == S_TLR) m_latch = 4'h2;
  endtask

  task automatic sample_strobes();
    if (cap) begin got_cap++; check1("cap_width", prev_cap, 0); end
    if (upd) begin got_upd++; check1("upd_width", prev_upd, 0); end
    if (shf) begin
      got_shift++;
      check1("shf_width", prev_shf, 0);
      check1("debug_tdi", dbg_tdi, tdi);
    end
    prev_cap = cap; prev_shf = shf; prev_upd = upd;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_strobes();
    end
  endtask

  task automatic compare_model();
    check1("tlr", tlr, (m_state == S_TLR));
    check1("rti", rti, (m_state == S_RTI));
    check1("dsel", dsel, (m_latch == 4'h8));
    check1("tdo_oe", tdo_oe, exp_oe);
    if (exp_oe) check1("tdo", tdo, exp_tdo);
    check1("n_capture", got_cap, exp_cap);
    check1("n_shift", got_shift, exp_shift);
    check1("n_update", got_upd, exp_upd);
    if (tdo_oe) begin
      rx = {tdo, rx[31:1]};
      oe_n++;
    end
  endtask

  task automatic tck_cycle(input logic t_ms, input logic t_di, input logic d_tdo);
    tms = t_ms; tdi = t_di; dbg_tdo = d_tdo;
    model_step(t_ms, t_di, d_tdo);
    tck = 1'b1;
    wait_neg(4);
    tck = 1'b0;
    wait_neg(4);
    compare_model();
    $display("tck tms=%0b tdi=%0b -> state=%0d oe=%0b tdo=%0b", t_ms, t_di, m_state, tdo_oe, tdo);
  endtask

  // From RTI: scan n DR bits, dbg holds the debug_tdo_i bits in tdo order.
  task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dbg);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    tck_cycle(0, 0, dbg[0]);
    for (int i = 0; i < n; i++)
      tck_cycle((i == n - 1), din[i], (i + 1 < n) ? dbg[i+1] : 1'b0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
  endtask

  task automatic shift_ir(input logic [3:0] v);
    tck_cycle(1, 0, 0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    tck_cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) tck_cycle((i == 3), v[i], 0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, u0, o0;
    model_reset();
    wait_neg(3);
    check1("rst_tdo", tdo, 0);
    check1("rst_oe", tdo_oe, 0);
    check1("rst_strobes", {cap, shf, upd}, 3'b000);
    check1("rst_dsel", dsel, 0);
    check1("rst_tlr", tlr, 1);
    check1("rst_rti", rti, 0);
    rst_n = 1'b1;
    wait_neg(4);

    repeat (5) tck_cycle(1, 0, 0);
    check1("tlr_after_5", tlr, 1);
    tck_cycle(0, 0, 0);
    check1("rti_entry", rti, 1);

    o0 = oe_n;
    shift_dr(32, 32'h0, 32'h0);
    check1("idcode_read", rx, 32'h149511c3);
    check1("idcode_oe_cycles", oe_n - o0, 32);
    check1("oe_after_shift", tdo_oe, 0);

    shift_ir(4'hF);
    check1("ir_capture_out", rx[31:28], 4'b0001);
    shift_dr(4, 32'b1101, 32'h0);
    check1("bypass_delay", rx[31:28], 4'b1010);

    shift_ir(4'h8);
    check1("debug_selected", dsel, 1);
    c0 = got_cap; s0 = got_shift; u0 = got_upd;
    shift_dr(8, 32'h0, 32'hA5);
    check1("debug_tdo_path", rx[31:24], 8'hA5);
    check1("debug_n_cap", got_cap - c0, 1);
    check1("debug_n_shift", got_shift - s0, 8);
    check1("debug_n_upd", got_upd - u0, 1);

    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    tck_cycle(0, 0, 0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    repeat (5) tck_cycle(1, 0, 0);
    check1("pause_to_tlr", tlr, 1);
    check1("pause_dsel_clear", dsel, 0);

    tck_cycle(0, 0, 0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    tck_cycle(0, 0, 0);
    repeat (10) tck_cycle(0, 1, 0);
    check1("midshift_oe", tdo_oe, 1);
    tck = 1'b1;
    wait_neg(2);
    rst_n = 1'b0;
    #1;
    check1("arst_tdo", tdo, 0);
    check1("arst_oe", tdo_oe, 0);
    check1("arst_strobes", {cap, shf, upd}, 3'b000);
    check1("arst_dsel", dsel, 0);
    check1("arst_tlr", tlr, 1);
    check1("arst_rti", rti, 0);
    model_reset();
    tms = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(6);
    check1("no_edge_at_release", tlr, 1);
    tck = 1'b0;
    wait_neg(4);
    compare_model();
    tck_cycle(0, 0, 0);
    shift_dr(32, 32'h0, 32'h0);
    check1("idcode_after_reset", rx, 32'h149511c3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
